data_mem_ctrl: RTL and testbench

Data-memory controller between the CPU's MEM-stage memory port and an external handshaked data memory. Stores retire into a posted store buffer so the pipeline never waits on write latency. Loads are forwarded from the buffer when they hit; a miss stalls the CPU through a read transaction. The block owns the external bus and serialises buffer drains and read misses onto it, one transaction at a time.

---
 rtl/data_mem_ctrl.sv | 171 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: posted store buffer with store-to-load forwarding,
// serialising buffer drains and load misses onto one handshaked external bus.
module data_mem_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_memRead_i,
    input  logic              cpu_memWrite_i,
    input  logic [ADDR_W-1:0] cpu_memAddr_i,
    input  logic [DATA_W-1:0] cpu_memData_i,
    output logic [DATA_W-1:0] cpu_memData_o,
    output logic              stall_o,
    output logic              ext_req_o,
    output logic              ext_we_o,
    output logic [ADDR_W-1:0] ext_addr_o,
    output logic [DATA_W-1:0] ext_wdata_o,
    input  logic              ext_ack_i,
    input  logic [DATA_W-1:0] ext_rdata_i,
    output logic [1:0]        debug_state,
    output logic [CW-1:0]     debug_count
);

    // External handshake: ext_req_o and its qualifiers are registered and held
    // until a rising edge sees ext_req_o=1 with ext_ack_i=1; that edge completes
    // the transaction, and a new one may be presented from the very next cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        READ  = 2'd2,
        RDONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] buf_addr [DEPTH];
    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [PW-1:0]     head_q;
    logic [PW-1:0]     tail_q;
    logic [PW-1:0]     head_nxt;
    logic [CW-1:0]     count_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              load_req;
    logic              full;
    logic              push;
    logic              pop;
    logic              hit;
    logic              miss;
    logic [DATA_W-1:0] hit_data;
    logic [PW-1:0]     idx;

    // A simultaneous read and write is treated as a store only.
    assign load_req = cpu_memRead_i && !cpu_memWrite_i;
    assign full     = (count_q == CW'(DEPTH));
    assign push     = cpu_memWrite_i && !full;
    assign pop      = (state_q == DRAIN) && ext_ack_i;
    assign head_nxt = head_q + PW'(1);

    // Scan oldest to newest so the newest matching entry overrides older ones.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (buf_addr[idx] == cpu_memAddr_i)) begin
                hit      = 1'b1;
                hit_data = buf_data[idx];
            end
        end
    end

    assign miss    = load_req && !hit && (state_q != RDONE);
    assign stall_o = (cpu_memWrite_i && full) || miss;

    always_comb begin
        cpu_memData_o = '0;
        if (state_q == RDONE) begin
            cpu_memData_o = rd_data_q;
        end else if (load_req && hit) begin
            cpu_memData_o = hit_data;
        end
    end

    assign debug_state = state_q;
    assign debug_count = count_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_addr[tail_q] <= cpu_memAddr_i;
            buf_data[tail_q] <= cpu_memData_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            ext_req_o   <= 1'b0;
            ext_we_o    <= 1'b0;
            ext_addr_o  <= '0;
            ext_wdata_o <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_nxt;
            end
            count_q <= count_q + CW'(push) - CW'(pop);

            case (state_q)
                IDLE: begin
                    if (miss) begin
                        state_q     <= READ;
                        ext_req_o   <= 1'b1;
                        ext_we_o    <= 1'b0;
                        ext_addr_o  <= cpu_memAddr_i;
                        ext_wdata_o <= '0;
                    end else if (count_q != '0) begin
                        state_q     <= DRAIN;
                        ext_req_o   <= 1'b1;
                        ext_we_o    <= 1'b1;
                        ext_addr_o  <= buf_addr[head_q];
                        ext_wdata_o <= buf_data[head_q];
                    end
                end
                DRAIN: begin
                    // The write in flight always completes; a pending miss
                    // goes straight to the bus once it does.
                    if (ext_ack_i) begin
                        if (miss) begin
                            state_q     <= READ;
                            ext_we_o    <= 1'b0;
                            ext_addr_o  <= cpu_memAddr_i;
                            ext_wdata_o <= '0;
                        end else if (count_q > CW'(1)) begin
                            ext_addr_o  <= buf_addr[head_nxt];
                            ext_wdata_o <= buf_data[head_nxt];
                        end else begin
                            state_q   <= IDLE;
                            ext_req_o <= 1'b0;
                            ext_we_o  <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (ext_ack_i) begin
                        state_q   <= RDONE;
                        rd_data_q <= ext_rdata_i;
                        ext_req_o <= 1'b0;
                    end
                end
                RDONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: an external-memory responder with
// programmable ack latency and a scoreboard of expected bus transactions.
module tb_data_mem_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        cpu_memRead_i;
    logic        cpu_memWrite_i;
    logic [15:0] cpu_memAddr_i;
    logic [15:0] cpu_memData_i;
    logic [15:0] cpu_memData_o;
    logic        stall_o;
    logic        ext_req_o;
    logic        ext_we_o;
    logic [15:0] ext_addr_o;
    logic [15:0] ext_wdata_o;
    logic        ext_ack_i;
    logic [15:0] ext_rdata_i;
    logic [1:0]  debug_state;
    logic [2:0]  debug_count;

    int n_checks = 0;
    int n_errors = 0;
    int ack_wait = -1;
    int req_age  = 0;
    logic [15:0] rd_value = 16'h0;
    logic [32:0] exp_q[$];

    data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_memRead_i  (cpu_memRead_i),
        .cpu_memWrite_i (cpu_memWrite_i),
        .cpu_memAddr_i  (cpu_memAddr_i),
        .cpu_memData_i  (cpu_memData_i),
        .cpu_memData_o  (cpu_memData_o),
        .stall_o        (stall_o),
        .ext_req_o      (ext_req_o),
        .ext_we_o       (ext_we_o),
        .ext_addr_o     (ext_addr_o),
        .ext_wdata_o    (ext_wdata_o),
        .ext_ack_i      (ext_ack_i),
        .ext_rdata_i    (ext_rdata_i),
        .debug_state    (debug_state),
        .debug_count    (debug_count)
    );

    // Clock and reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completed bus transaction is compared in order.
    always @(posedge clk_i) begin
        logic [32:0] obs;
        if (!rst_i && ext_req_o && ext_ack_i) begin
            obs = {ext_we_o, ext_addr_o, (ext_we_o ? ext_wdata_o : 16'h0)};
            check("ext_txn_expected", 40'(exp_q.size() > 0), 40'd1);
            if (exp_q.size() > 0) begin
                check("ext_txn", 40'(obs), 40'(exp_q.pop_front()));
            end
        end
        if (rst_i || !ext_req_o || ext_ack_i) req_age = 0;
        else req_age++;
    end

    // External memory responder: acks after ack_wait request cycles, never if negative.
    always @(negedge clk_i) begin
        ext_ack_i   = ext_req_o && (ack_wait >= 0) && (req_age >= ack_wait);
        ext_rdata_i = rd_value;
    end

    // Driver tasks
    task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk_i);
        cpu_memRead_i  = rd;
        cpu_memWrite_i = wr;
        cpu_memAddr_i  = a;
        cpu_memData_i  = d;
        #1;
    endtask

    task automatic wait_drained(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            drive(1'b0, 1'b0, 16'h0, 16'h0);
            if (debug_count == 3'd0 && debug_state == 2'd0 && !ext_req_o) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, 40'(done), 40'd1);
    endtask

    initial begin
        int first;
        int hi;
        int n_stall;
        logic any_stall;
        logic [15:0] d [5];

        rst_i          = 1'b1;
        cpu_memRead_i  = 1'b0;
        cpu_memWrite_i = 1'b0;
        cpu_memAddr_i  = 16'h0;
        cpu_memData_i  = 16'h0;
        ext_ack_i      = 1'b0;
        ext_rdata_i    = 16'h0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_stall", 40'(stall_o), 40'd0);
        check("rst_req", 40'(ext_req_o), 40'd0);
        check("rst_we", 40'(ext_we_o), 40'd0);
        check("rst_addr", 40'(ext_addr_o), 40'd0);
        check("rst_wdata", 40'(ext_wdata_o), 40'd0);
        check("rst_rdata", 40'(cpu_memData_o), 40'd0);
        check("rst_count", 40'(debug_count), 40'd0);
        check("rst_state", 40'(debug_state), 40'd0);

        // Single store, ack after two wait cycles
        ack_wait = 2;
        drive(1'b0, 1'b1, 16'h0010, 16'h1234);
        exp_q.push_back({1'b1, 16'h0010, 16'h1234});
        check("t1_store_stall", 40'(stall_o), 40'd0);
        first = -1;
        hi = 0;
        any_stall = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b0, 16'h0, 16'h0);
            any_stall = any_stall | stall_o;
            if (ext_req_o) begin
                if (first < 0) first = i;
                hi++;
            end
        end
        check("t1_req_start", 40'(first), 40'd1);
        check("t1_req_len", 40'(hi), 40'd3);
        check("t1_no_stall", 40'(any_stall), 40'd0);
        check("t1_count", 40'(debug_count), 40'd0);

        // Two stores to one address, forwarding returns the newest
        ack_wait = -1;
        drive(1'b0, 1'b1, 16'h0020, 16'hAAAA);
        exp_q.push_back({1'b1, 16'h0020, 16'hAAAA});
        check("t2_store_a_stall", 40'(stall_o), 40'd0);
        drive(1'b0, 1'b1, 16'h0020, 16'hBBBB);
        exp_q.push_back({1'b1, 16'h0020, 16'hBBBB});
        check("t2_store_b_stall", 40'(stall_o), 40'd0);
        drive(1'b1, 1'b0, 16'h0020, 16'h0);
        check("t2_hit_data", 40'(cpu_memData_o), 40'hBBBB);
        check("t2_hit_stall", 40'(stall_o), 40'd0);
        check("t2_bus_still_write", 40'(ext_we_o), 40'd1);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        check("t2_idle_rdata", 40'(cpu_memData_o), 40'd0);
        ack_wait = 0;
        wait_drained("t2_drained");

        // Load miss from IDLE, ack on first request cycle
        rd_value = 16'hBEEF;
        drive(1'b1, 1'b0, 16'h0040, 16'h0);
        exp_q.push_back({1'b0, 16'h0040, 16'h0});
        check("t3_c0_stall", 40'(stall_o), 40'd1);
        check("t3_c0_rdata", 40'(cpu_memData_o), 40'd0);
        drive(1'b1, 1'b0, 16'h0040, 16'h0);
        check("t3_c1_stall", 40'(stall_o), 40'd1);
        check("t3_c1_bus", 40'({ext_req_o, ext_we_o, ext_addr_o}), 40'({1'b1, 1'b0, 16'h0040}));
        drive(1'b1, 1'b0, 16'h0040, 16'h0);
        check("t3_c2_stall", 40'(stall_o), 40'd0);
        check("t3_c2_rdata", 40'(cpu_memData_o), 40'hBEEF);
        check("t3_c2_state", 40'(debug_state), 40'd3);
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        check("t3_after_rdata", 40'(cpu_memData_o), 40'd0);
        check("t3_after_state", 40'(debug_state), 40'd0);

        // Fill the buffer with acks held off; fifth store waits for a pop
        ack_wait = -1;
        for (int i = 0; i < 5; i++) d[i] = 16'($urandom_range(0, 65535));
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 16'(16'h0100 + i), d[i]);
            exp_q.push_back({1'b1, 16'(16'h0100 + i), d[i]});
            check("t4_store_stall", 40'(stall_o), 40'd0);
        end
        drive(1'b0, 1'b1, 16'h0104, d[4]);
        check("t4_full_stall", 40'(stall_o), 40'd1);
        check("t4_full_count", 40'(debug_count), 40'd4);
        ack_wait = 0;
        drive(1'b0, 1'b1, 16'h0104, d[4]);
        check("t4_pop_cycle_stall", 40'(stall_o), 40'd1);
        drive(1'b0, 1'b1, 16'h0104, d[4]);
        exp_q.push_back({1'b1, 16'h0104, d[4]});
        check("t4_accept_stall", 40'(stall_o), 40'd0);
        check("t4_accept_count", 40'(debug_count), 40'd3);
        wait_drained("t4_drained");

        // Load miss while a drain is in flight
        ack_wait = -1;
        rd_value = 16'h4321;
        drive(1'b0, 1'b1, 16'h0070, 16'h7777);
        exp_q.push_back({1'b1, 16'h0070, 16'h7777});
        drive(1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 16'h0080, 16'h0);
        exp_q.push_back({1'b0, 16'h0080, 16'h0});
        check("t5_miss_stall", 40'(stall_o), 40'd1);
        check("t5_miss_state", 40'(debug_state), 40'd1);
        n_stall = 1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 16'h0080, 16'h0);
            if (i == 0) ack_wait = 0;
            if (!stall_o) break;
            n_stall++;
        end
        check("t5_stall_cycles", 40'(n_stall), 40'd4);
        check("t5_rdata", 40'(cpu_memData_o), 40'h4321);
        drive(1'b0, 1'b0, 16'h0, 16'h0);

        // Reset during READ with two entries buffered
        ack_wait = -1;
        drive(1'b0, 1'b1, 16'h0090, 16'h0001);
        exp_q.push_back({1'b1, 16'h0090, 16'h0001});
        drive(1'b0, 1'b1, 16'h0091, 16'h0002);
        drive(1'b0, 1'b1, 16'h0092, 16'h0003);
        ack_wait = 0;
        drive(1'b1, 1'b0, 16'h00A0, 16'h0);
        ack_wait = -1;
        drive(1'b1, 1'b0, 16'h00A0, 16'h0);
        check("t6_read_state", 40'(debug_state), 40'd2);
        check("t6_read_count", 40'(debug_count), 40'd2);
        check("t6_read_bus", 40'({ext_req_o, ext_we_o, stall_o}), 40'({1'b1, 1'b0, 1'b1}));
        @(negedge clk_i);
        rst_i          = 1'b1;
        cpu_memRead_i  = 1'b0;
        cpu_memWrite_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("t6_rst_req", 40'(ext_req_o), 40'd0);
        check("t6_rst_stall", 40'(stall_o), 40'd0);
        check("t6_rst_count", 40'(debug_count), 40'd0);
        check("t6_rst_state", 40'(debug_state), 40'd0);
        repeat (4) drive(1'b0, 1'b0, 16'h0, 16'h0);
        check("t6_quiet_bus", 40'(ext_req_o), 40'd0);

        check("exp_q_empty", 40'(exp_q.size()), 40'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
